alu_arbiter: RTL

- Shares one combinational 32-bit ALU between two requesters, for example the main datapath and an address-generation or debug unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin.
- Operands, operation and owner are registered before they reach the ALU. The ALU result and Zero flag are registered before they are returned to the owner.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_arbiter_if.sv | 33 +++
 rtl/alu_rr_arb.sv | 24 ++
 rtl/alu_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
//   DATA_W      : operand / result width
//   CTRL_W      : ALU control code width
//   alu_op_e    : control codes understood by the current ALU (arbiter never decodes them)
//   arb_state_e : arbiter transaction states
package alu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CTRL_W = 3;

   typedef enum logic [CTRL_W-1:0] {
      ADD = 3'b000,
      SUB = 3'b001,
      AND = 3'b010,
      OR  = 3'b011,
      SRL = 3'b101
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } arb_state_e;

   // Requester index to its bit in a 2-bit valid/ready vector.
   function automatic logic [1:0] idx_to_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between the two requesters and the ALU arbiter.
//   req_valid/req_ready : per-requester request handshake (bit i = requester i)
//   req_a*/req_b*/req_ctrl* : per-requester operands and control code
//   rsp_valid/rsp_ready : per-requester response handshake
//   rsp_result/rsp_zero : response payload, shared by both requesters
// Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if;
   import alu_pkg::*;

   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [DATA_W-1:0] req_a0;
   logic [DATA_W-1:0] req_b0;
   logic [CTRL_W-1:0] req_ctrl0;
   logic [DATA_W-1:0] req_a1;
   logic [DATA_W-1:0] req_b1;
   logic [CTRL_W-1:0] req_ctrl1;
   logic [1:0]        rsp_valid;
   logic [1:0]        rsp_ready;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_zero;

   modport master (
      output req_valid, req_a0, req_b0, req_ctrl0, req_a1, req_b1, req_ctrl1, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_zero
   );

   modport slave (
      input  req_valid, req_a0, req_b0, req_ctrl0, req_a1, req_b1, req_ctrl1, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_zero
   );

endinterface

// File: rtl/alu_rr_arb.sv
// Combinational two-way round-robin grant.
//   req_valid   : request vector (bit i = requester i)
//   ptr         : priority pointer, wins when both requesters are valid
//   grant       : index of the granted requester
//   grant_valid : at least one requester is valid
module alu_rr_arb (
   input  logic [1:0] req_valid,
   input  logic       ptr,
   output logic       grant,
   output logic       grant_valid
);

   always_comb begin
      grant       = 1'b0;
      grant_valid = |req_valid;
      unique case (req_valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ptr;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
// Operands/control/owner are registered on acceptance (IDLE -> EXEC), the ALU
// result and Zero flag are registered one cycle later (EXEC -> RESP), and the
// response is held until the owner accepts it (RESP -> IDLE).
//   clk, rst_n            : clock, asynchronous active-low reset
//   bus                   : request/response bus (slave modport)
//   alu_srca/alu_srcb     : registered ALU operands
//   alu_ctrl              : registered ALU control code
//   alu_result, alu_zero  : combinational ALU outputs
module alu_arbiter
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   alu_arbiter_if.slave      bus,
   output logic [DATA_W-1:0] alu_srca,
   output logic [DATA_W-1:0] alu_srcb,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero
);

   arb_state_e        state_q, state_d;
   logic              ptr_q;
   logic              owner_q;
   logic [DATA_W-1:0] srca_q, srcb_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [DATA_W-1:0] result_q;
   logic              zero_q;

   logic              grant;
   logic              grant_valid;
   logic              accept;
   logic              capture;
   logic [DATA_W-1:0] sel_a, sel_b;
   logic [CTRL_W-1:0] sel_ctrl;

   alu_rr_arb u_rr_arb (
      .req_valid   (bus.req_valid),
      .ptr         (ptr_q),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   assign sel_a    = grant ? bus.req_a1    : bus.req_a0;
   assign sel_b    = grant ? bus.req_b1    : bus.req_b0;
   assign sel_ctrl = grant ? bus.req_ctrl1 : bus.req_ctrl0;

   // Next state; accept/capture mark the edges that load the operand and
   // result registers.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               accept  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            capture = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            // Only the owner's ready completes the response.
            if (bus.rsp_ready[owner_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Ready is gated by rst_n so nothing looks accepted while reset is held.
   always_comb begin
      bus.req_ready = 2'b00;
      if (rst_n && (state_q == IDLE) && grant_valid) begin
         bus.req_ready = idx_to_onehot(grant);
      end
   end

   always_comb begin
      bus.rsp_valid = 2'b00;
      if (state_q == RESP) begin
         bus.rsp_valid = idx_to_onehot(owner_q);
      end
   end

   assign bus.rsp_result = result_q;
   assign bus.rsp_zero   = zero_q;
   assign alu_srca       = srca_q;
   assign alu_srcb       = srcb_q;
   assign alu_ctrl       = ctrl_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         srca_q  <= '0;
         srcb_q  <= '0;
         ctrl_q  <= '0;
      end else if (accept) begin
         ptr_q   <= ~grant;
         owner_q <= grant;
         srca_q  <= sel_a;
         srcb_q  <= sel_b;
         ctrl_q  <= sel_ctrl;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         zero_q   <= 1'b0;
      end else if (capture) begin
         result_q <= alu_result;
         zero_q   <= alu_zero;
      end
   end

endmodule
